// File: rtl/vluint_decoder.sv
// vluint_decoder -- LEB128 / SLEB128 variable-length integer decoder.
//
// Fetches encoded bytes one at a time over a request/ack port. Each byte
// contributes its 7-bit group LSB-first to an accumulator. When the
// terminating byte arrives (bit 7 clear) or the byte limit is reached, the
// decoded value and the address following the last consumed byte are
// presented with a one-cycle rd_o pulse.
//
// Optional feature macro: VLUINT_ZIGZAG_EN
//   Adds input zz_i, latched with beg_i. When zz_i=1 the result is
//   zigzag-decoded ((acc>>1) ^ -(acc&1)) and SIGNED_MODE extension is skipped.
//
// Ports:
//   clk_i       clock, all logic on rising edge
//   reset_i     asynchronous active-low reset
//   beg_i       start request (accepted in IDLE, including the rd_o cycle)
//   addr_i      address of first encoded byte, latched with beg_i
//   zz_i        zigzag select (only with VLUINT_ZIGZAG_EN)
//   mem_addr_o  byte address to fetch
//   mem_rd_o    one-cycle fetch strobe
//   mem_ack_i   mem_data_i valid for the outstanding fetch
//   mem_data_i  fetched byte
//   rd_o        one-cycle result-valid pulse
//   data_o      decoded value, held
//   addr_out_o  address after last consumed byte, held
//   err_o       overflow / over-length flag, valid with rd_o
//   busy_o      high from beg acceptance until the edge that raises rd_o
module vluint_decoder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BYTES   = (DATA_WIDTH + 6) / 7,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  beg_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
`ifdef VLUINT_ZIGZAG_EN
  input  logic                  zz_i,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic                  mem_ack_i,
  input  logic [7:0]            mem_data_i,
  output logic                  rd_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] addr_out_o,
  output logic                  err_o,
  output logic                  busy_o
);

  // Wide enough that a 7-bit group at the largest shift never falls off,
  // so every bit landing above DATA_WIDTH is visible to the overflow check.
  localparam int WIDE_W  = DATA_WIDTH + 7 * MAX_BYTES;
  localparam int SHIFT_W = $clog2(WIDE_W + 1);
  localparam int CNT_W   = $clog2(MAX_BYTES + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic [CNT_W-1:0]        count_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_q;
  logic                    rd_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADDR_WIDTH-1:0]   addr_out_q;
  logic                    busy_q;
`ifdef VLUINT_ZIGZAG_EN
  logic                    zz_q;
`endif

  logic [WIDE_W-1:0]       grp_wide;
  logic [DATA_WIDTH-1:0]   acc_d;
  logic [SHIFT_W-1:0]      shift_d;
  logic [CNT_W-1:0]        count_d;
  logic [ADDR_WIDTH-1:0]   ptr_d;
  logic                    err_d;
  logic                    more_d;
  logic [DATA_WIDTH-1:0]   ext_mask;
  logic [DATA_WIDTH-1:0]   result_d;

  always_comb begin
    grp_wide = WIDE_W'(mem_data_i[6:0]) << shift_q;
    acc_d    = acc_q | grp_wide[DATA_WIDTH-1:0];
    shift_d  = shift_q + SHIFT_W'(7);
    count_d  = count_q + CNT_W'(1);
    ptr_d    = ptr_q + ADDR_WIDTH'(1);
    // Continue only while the limit has room; a continuation byte at the
    // limit ends the decode with err set.
    more_d   = mem_data_i[7] && (count_d < CNT_W'(MAX_BYTES));
    err_d    = err_q | (|grp_wide[WIDE_W-1:DATA_WIDTH]) | (mem_data_i[7] & ~more_d);
    ext_mask = {DATA_WIDTH{1'b1}} << shift_d;
  end

  always_comb begin
    result_d = acc_d;
`ifdef VLUINT_ZIGZAG_EN
    if (zz_q) begin
      result_d = {1'b0, acc_d[DATA_WIDTH-1:1]} ^ {DATA_WIDTH{acc_d[0]}};
    end else
`endif
    if ((SIGNED_MODE != 0) && mem_data_i[6] && (int'(shift_d) < DATA_WIDTH)) begin
      result_d = acc_d | ext_mask;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      acc_q      <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_q       <= 1'b0;
      data_q     <= '0;
      addr_out_q <= '0;
      busy_q     <= 1'b0;
`ifdef VLUINT_ZIGZAG_EN
      zz_q       <= 1'b0;
`endif
    end else begin
      rd_q     <= 1'b0;
      mem_rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // mem_ack_i is deliberately ignored here (late acks after reset).
          if (beg_i) begin
            ptr_q      <= addr_i;
            acc_q      <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= addr_i;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
`ifdef VLUINT_ZIGZAG_EN
            zz_q       <= zz_i;
`endif
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            if (more_d) begin
              mem_addr_q <= ptr_d;
              mem_rd_q   <= 1'b1;
            end else begin
              data_q     <= result_d;
              addr_out_q <= ptr_d;
              rd_q       <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o   = mem_rd_q;
  assign rd_o       = rd_q;
  assign data_o     = data_q;
  assign addr_out_o = addr_out_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;

endmodule
